alu_seq_ctrl: RTL



---
 rtl/alu_seq_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Bit-serial ALU sequencer: one operation is evaluated LSB-first through a
// single 1-bit gate slice, with valid/ready handshakes on both sides.
module alu_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_ADD  = 3'b110;
   localparam logic [2:0] OP_SUB  = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] work;
   logic [CW-1:0]    cnt;
   logic             c_q;

   logic             ai;
   logic             bi;
   logic             bx;
   logic             sum;
   logic             c_nx;
   logic             bit_r;
   logic             arith;
   logic [WIDTH-1:0] word;

   // The single shared slice: gate bit plus full-adder carry logic.
   always_comb begin
      ai    = a_q[cnt];
      bi    = b_q[cnt];
      bx    = (op_q == OP_SUB) ? ~bi : bi;
      sum   = ai ^ bx ^ c_q;
      c_nx  = (ai & bx) | (ai & c_q) | (bx & c_q);
      arith = op_q[2] & op_q[1];
      bit_r = 1'b0;
      unique case (op_q)
         OP_AND:  bit_r = ai & bi;
         OP_OR:   bit_r = ai | bi;
         OP_XOR:  bit_r = ai ^ bi;
         OP_NOT:  bit_r = ~ai;
         OP_NAND: bit_r = ~(ai & bi);
         OP_NOR:  bit_r = ~(ai | bi);
         OP_ADD:  bit_r = sum;
         OP_SUB:  bit_r = sum;
      endcase
      word = {bit_r, work[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         work      <= '0;
         cnt       <= '0;
         c_q       <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         zero      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q     <= op;
                  a_q      <= a;
                  b_q      <= b;
                  cnt      <= '0;
                  c_q      <= (op == OP_SUB);
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               work <= word;
               c_q  <= c_nx;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  result    <= word;
                  carry_out <= arith & c_nx;
                  zero      <= (word == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule
